// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial data stage: sizing defaults, state
// encoding and the bit-order index helper used by both shift paths.
package spi_pkg;

  localparam int MAX_CHAR_DEF = 32;
  localparam int CNT_W_DEF    = $clog2(MAX_CHAR_DEF) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } spi_state_e;

  // Position in the data word of the n-th transferred bit.
  function automatic logic [CNT_W_DEF-1:0] bit_index(
    input logic [CNT_W_DEF-1:0] n,
    input logic [CNT_W_DEF-1:0] len,
    input logic                 lsb_first
  );
    logic [CNT_W_DEF-1:0] idx;
    if (lsb_first) begin
      idx = n;
    end else begin
      idx = len - n - CNT_W_DEF'(1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// SPI master serial data stage: shifts the TX word out on mosi, samples miso into rx_data.
// Optional build macro SPI_SHIFT_LOOPBACK_EN adds a loopback input that feeds mosi to the sampler.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int MAX_CHAR = MAX_CHAR_DEF,
  parameter int CNT_W    = $clog2(MAX_CHAR) + 1
) (
  input  logic                wb_clk_in,
  input  logic                wb_rst_n,
  input  logic                pos_edge,
  input  logic                neg_edge,
  input  logic                go,
  input  logic                wr_en,
  input  logic [MAX_CHAR-1:0] tx_data,
  input  logic [CNT_W-1:0]    char_len,
  input  logic                lsb_first,
  input  logic                tx_negedge,
  input  logic                rx_negedge,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                loopback,
`endif
  input  logic                miso,
  output logic                tip,
  output logic                last_clk,
  output logic                mosi,
  output logic [MAX_CHAR-1:0] rx_data,
  output logic                done
);

  localparam int              IDX_W   = $clog2(MAX_CHAR);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_CHAR);

  spi_state_e          state_r;
  spi_state_e          state_nxt_s;
  logic [MAX_CHAR-1:0] tx_buf_r;
  logic [MAX_CHAR-1:0] rx_data_r;
  logic [CNT_W-1:0]    tx_cnt_r;
  logic [CNT_W-1:0]    rx_cnt_r;
  logic [CNT_W-1:0]    len_r;
  logic                tip_r;
  logic                last_clk_r;
  logic                mosi_r;
  logic                done_r;

  logic [CNT_W-1:0]    len_eff_s;
  logic [CNT_W-1:0]    tx_idx_s;
  logic [CNT_W-1:0]    rx_idx_s;
  logic [CNT_W-1:0]    tx_cnt_nxt_s;
  logic [MAX_CHAR-1:0] rx_mask_s;
  logic                tx_fire_s;
  logic                rx_fire_s;
  logic                rx_last_s;
  logic                rx_bit_s;

  // Strobe qualification, bit indices and the keep-mask applied to rx_data at go.
  always_comb begin
    len_eff_s    = (char_len == {CNT_W{1'b0}}) ? MAX_LEN : char_len;
    tx_fire_s    = (state_r == XFER) && (tx_negedge ? neg_edge : pos_edge) && (tx_cnt_r < len_r);
    rx_fire_s    = (state_r == XFER) && (rx_negedge ? neg_edge : pos_edge) && (rx_cnt_r < len_r);
    rx_last_s    = rx_fire_s && ((rx_cnt_r + CNT_W'(1)) == len_r);
    tx_cnt_nxt_s = tx_fire_s ? (tx_cnt_r + CNT_W'(1)) : tx_cnt_r;
    tx_idx_s     = bit_index(tx_cnt_r, len_r, lsb_first);
    rx_idx_s     = bit_index(rx_cnt_r, len_r, lsb_first);
`ifdef SPI_SHIFT_LOOPBACK_EN
    rx_bit_s     = loopback ? mosi_r : miso;
`else
    rx_bit_s     = miso;
`endif
    for (int i = 0; i < MAX_CHAR; i++) begin
      rx_mask_s[i] = (CNT_W'(i) < len_eff_s);
    end
  end

  // Next-state logic: a transfer ends on the sample that completes the word.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (go) begin
          state_nxt_s = XFER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        if (rx_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = XFER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: TX buffer load, shift-out, sample-in and status flags.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tx_buf_r   <= {MAX_CHAR{1'b0}};
      rx_data_r  <= {MAX_CHAR{1'b0}};
      tx_cnt_r   <= {CNT_W{1'b0}};
      rx_cnt_r   <= {CNT_W{1'b0}};
      len_r      <= {CNT_W{1'b0}};
      tip_r      <= 1'b0;
      last_clk_r <= 1'b0;
      mosi_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (wr_en) begin
            tx_buf_r <= tx_data;
          end
          if (go) begin
            len_r      <= len_eff_s;
            tx_cnt_r   <= {CNT_W{1'b0}};
            rx_cnt_r   <= {CNT_W{1'b0}};
            tip_r      <= 1'b1;
            last_clk_r <= 1'b0;
            rx_data_r  <= rx_data_r & rx_mask_s;
          end
        end
        XFER: begin
          if (tx_fire_s) begin
            mosi_r   <= tx_buf_r[tx_idx_s[IDX_W-1:0]];
            tx_cnt_r <= tx_cnt_nxt_s;
          end
          if (rx_fire_s) begin
            rx_data_r[rx_idx_s[IDX_W-1:0]] <= rx_bit_s;
            rx_cnt_r <= rx_cnt_r + CNT_W'(1);
          end
          if (rx_last_s) begin
            tip_r      <= 1'b0;
            last_clk_r <= 1'b0;
            done_r     <= 1'b1;
          end else begin
            last_clk_r <= (tx_cnt_nxt_s == len_r);
          end
        end
        default: begin
          tip_r <= 1'b0;
        end
      endcase
    end
  end

  assign tip      = tip_r;
  assign last_clk = last_clk_r;
  assign mosi     = mosi_r;
  assign rx_data  = rx_data_r;
  assign done     = done_r;

endmodule

// File: doc/spi_shift_reg.md
Name: spi_shift_reg

Overview:
- Serial data stage directly downstream of the SPI clock generator.
- Consumes the generator's one-cycle edge strobes: pos_edge is asserted one wb_clk_in cycle before sclk rises, and neg_edge one cycle before it falls.
- Shifts a latched TX word out on mosi and samples miso into an RX word.
- Drives tip and last_clk back to the clock generator, so the two blocks together form the SPI master core.

Parameters:
- MAX_CHAR, 32, maximum transfer length in bits; also the TX/RX buffer width.
- CNT_W, $clog2(MAX_CHAR)+1, width of the bit counters and of char_len.

Ports:
- wb_clk_in  in  1  system clock; all logic is on its rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- pos_edge  in  1  strobe: sclk rises next cycle.
- neg_edge  in  1  strobe: sclk falls next cycle.
- go  in  1  one-cycle start request.
- wr_en  in  1  load tx_data into the TX buffer.
- tx_data  in  MAX_CHAR  word to transmit.
- char_len  in  CNT_W  transfer length in bits; 0 means MAX_CHAR.
- lsb_first  in  1  1 = LSB first, 0 = MSB first.
- tx_negedge  in  1  1 = change mosi on neg_edge, 0 = on pos_edge.
- rx_negedge  in  1  1 = sample miso on neg_edge, 0 = on pos_edge.
- miso  in  1  serial input.
- tip  out  1  transfer in progress.
- last_clk  out  1  final bit has been driven.
- mosi  out  1  serial output.
- rx_data  out  MAX_CHAR  received word.
- done  out  1  one-cycle pulse at transfer completion.

Behaviour:
- Reset values: tip=0, last_clk=0, mosi=0, done=0, rx_data=0, TX buffer=0, both counters=0, state IDLE.
- Asserting wb_rst_n low mid-transfer aborts immediately; there is no partial-result retention.
- State IDLE:
  - wr_en loads the TX buffer.
  - go samples len_eff = (char_len==0) ? MAX_CHAR : char_len, clears tx_cnt and rx_cnt, sets tip=1, and moves to XFER on the next edge.
  - wr_en and go in the same cycle: the new tx_data is used for the transfer.
- State XFER:
  - go and wr_en are ignored; the TX buffer is frozen.
  - tx strobe = tx_negedge ? neg_edge : pos_edge.
  - rx strobe = rx_negedge ? neg_edge : pos_edge.
- On each tx strobe with tx_cnt < len_eff:
  - mosi <= buf[idx(tx_cnt)], then tx_cnt++.
  - idx(n) = lsb_first ? n : len_eff-1-n.
- last_clk = tip && (tx_cnt == len_eff). It is registered and rises in the cycle after the final tx strobe.
- On each rx strobe with rx_cnt < len_eff:
  - rx_data[idx(rx_cnt)] <= miso, then rx_cnt++.
- When the rx strobe that takes rx_cnt to len_eff occurs:
  - next cycle: tip=0, last_clk=0, done=1 for exactly one cycle, return to IDLE.
  - rx_data holds its value until the next transfer's first sample.
- rx_data bits at or above len_eff are cleared when go is accepted.
- mosi holds the last driven bit after the transfer.
- If pos_edge and neg_edge arrive in the same cycle (illegal from the clock generator), tx and rx are still each evaluated independently.
- Strobes received in IDLE are ignored.
- The configuration inputs (char_len, lsb_first, tx_negedge, rx_negedge) must be stable during XFER. char_len is sampled only at go; the edge-select and bit-order inputs are used live.

Optional Feature:
- Macro: SPI_SHIFT_LOOPBACK_EN.
- When defined: adds input port loopback (1 bit). When loopback=1, the RX sampler takes mosi instead of miso, for self-test.
- When undefined: the port is absent and the sampler always uses miso.

Decomposition:
- Package spi_pkg holds:
  - the MAX_CHAR default;
  - the CNT_W computation;
  - the state enum (IDLE, XFER);
  - a function bit_index(n, len, lsb_first) shared by the TX and RX paths.
- No sub-module is needed; a single module, with the index function taken from spi_pkg.

Test Plan:
- tx_data=0xA5, char_len=8, MSB-first, tx on neg, rx on pos, miso looped to mosi -> mosi sequence 1,0,1,0,0,1,0,1; rx_data=0x000000A5; done pulses once; tip=0 afterwards.
- char_len=0 (32-bit), lsb_first=1, tx_data=0x80000001 -> first mosi bit 1, bits 2..31 are 0, 32nd bit 1; last_clk high only after the 32nd tx strobe.
- go during XFER, and wr_en=1 with 0xFF during XFER -> no restart; the buffer is unchanged; the next transfer sends the original word.
- wr_en and go in the same idle cycle with 0x3C, char_len=4 -> mosi sequence 1,1,0,0 (MSB-first over bits 3..0).
- Reset asserted after the 3rd bit of an 8-bit transfer -> tip, mosi, done and rx_data all 0 immediately; a following go starts a clean transfer.
- With SPI_SHIFT_LOOPBACK_EN defined, loopback=1 and miso tied to 0, tx_data=0x5A -> rx_data=0x5A.
